poly_coef_loader: RTL and testbench
===================================

Name: poly_coef_loader

Overview:
- Upstream feeder for the polynomial unit's data-in path. Accepts a stream of 12-bit coefficients with a valid/ready handshake and reduces each one modulo Q.
- Packs four reduced coefficients into each 48-bit RAM word and drives the unit's data_in / data_in_add / data_in_done / mode / run interface. One full load is 32 words = 128 coefficients.
- Sequences the poly unit's DATAIN mode, then reports completion or a timeout to the top-level controller.

Parameters:
WID, 12, coefficient width
LANES, 4, coefficients per RAM word
AWID, 5, word address width (32 words)
Q, 3329, modulus used for conditional reduction
HOLD_CYC, 2, cycles the last word is held before data_in_done is pulsed
TO_CYC, 16, maximum cycles to wait for pu_done after data_in_done

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin a load; honoured only in IDLE
coef_in  in  WID  raw coefficient, value 0..4095
coef_valid  in  1  coef_in is valid
coef_ready  out  1  loader accepts coef_in this cycle
pu_mode  out  2  mode to poly unit; 2'd2 (DATAIN) whenever not IDLE, otherwise 2'd0
pu_run  out  1  one-cycle run request
pu_data_in  out  WID*LANES  packed word; lane k occupies bits [12k+11:12k]
pu_data_in_add  out  AWID  word address
pu_data_in_done  out  1  one-cycle end-of-load pulse
pu_done  in  1  poly unit done pulse
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky timeout flag; cleared by rst or by an accepted start

Behaviour:
- Reset: state IDLE. All outputs are 0; internal counters and registers are 0.
- FSM states: IDLE, RUNREQ, LOAD, HOLD, DPULSE, WAITPU.
- IDLE -> RUNREQ on start.
- RUNREQ: pu_run=1 for exactly 1 cycle; then -> LOAD.
- LOAD:
  - coef_ready=1; a coefficient is accepted when coef_valid & coef_ready.
  - After the 128th accept -> HOLD.
- HOLD: coef_ready=0 for HOLD_CYC cycles; then -> DPULSE.
- DPULSE: pu_data_in_done=1 for 1 cycle; then -> WAITPU.
- WAITPU:
  - pu_done -> IDLE with done=1 on the same-edge transition, so done is high for 1 cycle while the state is IDLE.
  - If TO_CYC cycles pass without pu_done -> IDLE with err=1 and no done.
- Reduction: r = (c >= Q) ? c - Q : c. One subtraction is sufficient because c < 2Q. Result is 12-bit, combinational before packing.
- Packing:
  - A 2-bit lane counter and a 7-bit coefficient counter advance on each accept.
  - Lanes 0..2 are written into the pack register.
  - On a lane-3 accept, {r, pack[35:0]} is written into the output register in one cycle. pu_data_in_add <= word index (coef count >> 2) in the same cycle.
  - Coefficient i lands in word i/4, lane i%4.
- Output register holds its value until the next completed word. The poly unit writes every cycle while in DATAIN, so repeated writes of the same address/data are idempotent.
- Before word 0 completes, address 0 receives 0. This is overwritten by word 0.
- pu_data_in / pu_data_in_add are stable through HOLD and DPULSE. This guarantees the last word (address 31) is written before the unit leaves DATAIN.
- Gaps on coef_valid: counters hold; the output register holds.
- start while busy: ignored.
- pu_done outside WAITPU: ignored.
- pu_run is never asserted outside RUNREQ.
- Counter wrap: after address 31 the next load restarts at 0. Counters clear on entry to RUNREQ.
- Reset mid-load: immediate return to IDLE, all outputs 0. The poly unit is not notified; the top level resets both blocks together.

Decomposition:
- Shared package: Q, WID, AWID, the poly unit mode codes (M_NTT=0, M_INTT=1, M_DATAIN=2, M_DATAOUT=3) and the loader FSM state encoding.
- One sub-module, coef_modq_reduce: combinational conditional subtract. It is reused by later decode/sampler stages.

Test Plan:
- Reset, then start; feed coefficients 0..127 continuously with valid held high, pu_done returned 1 cycle after pu_data_in_done -> exactly one pu_run pulse with pu_mode=2; word 0 = {12'd3,12'd2,12'd1,12'd0}; address 31 holds {127,126,125,124}; data_in_done 1 cycle; done pulse; err=0.
- Coefficients 3328, 3329, 4095, 3330 -> word 0 = {12'd1, 12'd766, 12'd0, 12'd3328}.
- coef_valid toggling 1-0-1 (50% duty) over a full load -> all 32 words are correct; 128 accepts total; pu_data_in_add is monotonic 0..31.
- pu_done never returned -> err=1 exactly TO_CYC cycles after pu_data_in_done; no done; busy=0 afterwards. A new start clears err.
- start re-asserted during LOAD, plus a pu_done pulse injected during LOAD -> no second pu_run; the load completes normally.
- rst asserted after 50 coefficients -> all outputs 0 next cycle. A following full load produces correct data from address 0.

Source files
------------

// File: rtl/poly_coef_loader_pkg.sv
// Shared constants, poly unit mode codes and loader FSM encoding for the
// coefficient load path.
package poly_coef_loader_pkg;

  localparam int WID      = 12;
  localparam int LANES    = 4;
  localparam int AWID     = 5;
  localparam int NCOEF    = LANES << AWID;
  localparam int HOLD_CYC = 2;
  localparam int TO_CYC   = 16;
  localparam int TW       = $clog2(TO_CYC + 1);

  localparam logic [WID-1:0] Q         = WID'(3329);
  localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TO_CYC - 1);

  typedef enum logic [1:0] {
    M_NTT     = 2'd0,
    M_INTT    = 2'd1,
    M_DATAIN  = 2'd2,
    M_DATAOUT = 2'd3
  } pu_mode_e;

  typedef enum logic [2:0] {
    S_IDLE, S_RUNREQ, S_LOAD, S_HOLD, S_DPULSE, S_WAITPU
  } ld_state_e;

endpackage

// File: rtl/poly_coef_loader_reduce.sv
// Conditional subtract mod Q; valid only for inputs below 2Q, which holds for
// any 12-bit value with Q = 3329.
module coef_modq_reduce
  import poly_coef_loader_pkg::*;
#(
  parameter int             W = WID,
  parameter logic [W-1:0]   M = Q
) (
  input  logic [W-1:0] c,
  output logic [W-1:0] r
);

  assign r = (c >= M) ? c - M : c;

endmodule

// File: rtl/poly_coef_loader.sv
// Streams 128 reduced coefficients into the poly unit as 32 packed words,
// sequencing run / DATAIN / data_in_done and watching for pu_done.
module poly_coef_loader
  import poly_coef_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WID-1:0]        coef_in,
  input  logic                  coef_valid,
  output logic                  coef_ready,
  output logic [1:0]            pu_mode,
  output logic                  pu_run,
  output logic [WID*LANES-1:0]  pu_data_in,
  output logic [AWID-1:0]       pu_data_in_add,
  output logic                  pu_data_in_done,
  input  logic                  pu_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  ld_state_e                   state, state_nx;
  logic [6:0]                  cnt;
  logic [1:0]                  lane;
  logic [WID*(LANES-1)-1:0]    pack;
  logic [TW-1:0]               tmr;
  logic [WID-1:0]              r;
  logic                        acc;

  coef_modq_reduce u_red (.c(coef_in), .r(r));

  assign acc             = coef_valid & coef_ready;
  assign coef_ready      = (state == S_LOAD);
  assign pu_run          = (state == S_RUNREQ);
  assign pu_data_in_done = (state == S_DPULSE);
  assign busy            = (state != S_IDLE);
  assign pu_mode         = busy ? M_DATAIN : M_NTT;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_RUNREQ;
      S_RUNREQ: state_nx = S_LOAD;
      S_LOAD:   if (acc && cnt == 7'(NCOEF - 1)) state_nx = S_HOLD;
      S_HOLD:   if (tmr == HOLD_LAST) state_nx = S_DPULSE;
      S_DPULSE: state_nx = S_WAITPU;
      S_WAITPU: if (pu_done || tmr == TO_LAST) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      lane           <= '0;
      pack           <= '0;
      tmr            <= '0;
      pu_data_in     <= '0;
      pu_data_in_add <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      // one timer serves both HOLD and WAITPU; it restarts on every state change
      tmr   <= (state_nx != state) ? '0 : tmr + 1'b1;
      if (state == S_IDLE && start) begin
        cnt            <= '0;
        lane           <= '0;
        pack           <= '0;
        pu_data_in     <= '0;
        pu_data_in_add <= '0;
        err            <= 1'b0;
      end
      if (acc) begin
        cnt  <= cnt + 7'd1;
        lane <= lane + 2'd1;
        if (lane == 2'd3) begin
          pu_data_in     <= {r, pack};
          pu_data_in_add <= cnt[6:2];
        end else begin
          pack[lane*WID +: WID] <= r;
        end
      end
      if (state == S_WAITPU) begin
        if (pu_done)             done <= 1'b1;
        else if (tmr == TO_LAST) err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_poly_coef_loader.sv
// Scoreboard bench: the driver pushes each expected word as its 4th
// coefficient goes out; a negedge monitor pops and compares written words.
module tb_poly_coef_loader;

  localparam int HOLD_C = 2;
  localparam int TO_C   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] coef_in = '0;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [1:0]  pu_mode;
  logic        pu_run;
  logic [47:0] pu_data_in;
  logic [4:0]  pu_data_in_add;
  logic        pu_data_in_done;
  logic        pu_done = 1'b0;
  logic        busy, done, err;

  typedef struct {
    logic [4:0]  addr;
    logic [47:0] data;
  } wexp_t;

  wexp_t       exp_q[$];
  logic [11:0] cin[128];
  logic [47:0] ew[32];
  int          total = 0;
  int          bad = 0;
  int          runs = 0;
  int          acc_cnt = 0;

  always #5 clk = ~clk;

  poly_coef_loader dut (
    .clk(clk), .rst(rst), .start(start), .coef_in(coef_in),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .pu_mode(pu_mode),
    .pu_run(pu_run), .pu_data_in(pu_data_in), .pu_data_in_add(pu_data_in_add),
    .pu_data_in_done(pu_data_in_done), .pu_done(pu_done), .busy(busy),
    .done(done), .err(err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: at each negedge predict the coming edge's handshake; one
  // negedge after a lane-3 accept the output register must hold that word.
  initial begin : monitor
    int  lane = 0;
    bit  pend = 0;
    wexp_t w;
    forever begin
      @(negedge clk);
      if (pu_run) runs++;
      if (pend) begin
        pend = 0;
        if (exp_q.size() == 0) chk("word_unexpected", 64'(pu_data_in_add), 64'hffff);
        else begin
          w = exp_q.pop_front();
          chk("word_addr", 64'(pu_data_in_add), 64'(w.addr));
          chk("word_data", 64'(pu_data_in), 64'(w.data));
        end
      end
      if (rst) lane = 0;
      else if (coef_valid && coef_ready) begin
        acc_cnt++;
        if (lane == 3) pend = 1;
        lane = (lane + 1) % 4;
      end
    end
  end

  task automatic fill_seq(input int offs);
    for (int i = 0; i < 128; i++) cin[i] = 12'(i + offs);
    for (int w = 0; w < 32; w++)
      ew[w] = {12'(4*w+3), 12'(4*w+2), 12'(4*w+1), 12'(4*w)};
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {coef_ready, pu_mode, pu_run, pu_data_in, pu_data_in_add,
             pu_data_in_done, busy, done, err}, 64'd0);
  endtask

  task automatic run_load(input bit gap, input bit respond, input bit poke, input int abort_at);
    int i, cyc, k;
    bit hs, seen_done;
    runs = 0; acc_cnt = 0;
    start = 1; @(posedge clk); #1; start = 0;
    chk("runreq_run", 64'(pu_run), 1);
    chk("runreq_mode", 64'(pu_mode), 2);
    chk("runreq_err_clr", 64'(err), 0);
    chk("runreq_word0", {pu_data_in_add, pu_data_in}, 0);
    i = 0; cyc = 0;
    while (i < 128 && i != abort_at) begin
      coef_valid = gap ? cyc[0] : 1'b1;
      coef_in    = cin[i];
      start      = poke && (i == 20);
      pu_done    = poke && (i == 20);
      hs = coef_valid && coef_ready;
      if (hs && (i % 4) == 3) exp_q.push_back('{addr: 5'(i/4), data: ew[i/4]});
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
      if (cyc > 1000) begin
        chk("feed_timeout", 64'(i), 128);
        break;
      end
    end
    coef_valid = 0; start = 0; pu_done = 0;
    if (i == abort_at) begin
      rst = 1; @(posedge clk); #1; rst = 0;
      chk_all_zero("abort_outputs");
      return;
    end
    chk("hold_ready", 64'(coef_ready), 0);
    k = 0;
    while (!pu_data_in_done && k < 20) begin @(posedge clk); #1; k++; end
    chk("hold_len", 64'(k), HOLD_C);
    chk("dpulse_add", 64'(pu_data_in_add), 31);
    chk("dpulse_data", 64'(pu_data_in), 64'(ew[31]));
    chk("dpulse_mode", 64'(pu_mode), 2);
    @(posedge clk); #1;
    chk("dpulse_1cyc", 64'(pu_data_in_done), 0);
    if (respond) begin
      pu_done = 1; @(posedge clk); #1; pu_done = 0;
      chk("done_pulse", {busy, done, err, pu_mode}, {1'b0, 1'b1, 1'b0, 2'd0});
      @(posedge clk); #1;
      chk("done_1cyc", 64'(done), 0);
    end else begin
      k = 1; seen_done = 0;
      while (!err && k < 40) begin
        if (done) seen_done = 1;
        @(posedge clk); #1; k++;
      end
      chk("timeout_len", 64'(k), TO_C + 1);
      chk("timeout_nodone", 64'(seen_done | done), 0);
      chk("timeout_busy", 64'(busy), 0);
    end
    chk("run_pulses", 64'(runs), 1);
    chk("accepts", 64'(acc_cnt), 128);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_in");
    rst = 0;
    @(posedge clk); #1;
    chk_all_zero("reset_out");

    // sequential 0..127, prompt pu_done
    fill_seq(0);
    run_load(0, 1, 0, -1);

    // boundary values around Q in word 0
    fill_seq(0);
    cin[0] = 12'd3328; cin[1] = 12'd3329; cin[2] = 12'd4095; cin[3] = 12'd3330;
    ew[0]  = {12'd1, 12'd766, 12'd0, 12'd3328};
    run_load(0, 1, 0, -1);

    // 50% valid duty; inputs i+3329 reduce back to i
    fill_seq(3329);
    run_load(1, 1, 0, -1);

    // no pu_done: timeout, then next start clears err
    fill_seq(0);
    run_load(0, 0, 0, -1);
    chk("err_sticky", 64'(err), 1);

    // stray start and pu_done during LOAD
    run_load(0, 1, 1, -1);

    // reset mid-load, then a clean load from address 0
    run_load(0, 1, 0, 50);
    run_load(0, 1, 0, -1);

    repeat (2) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
